// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter for the multicycle MIPS core.
// Arbitrates one edge-triggered NMI and N_IRQ level-triggered maskable lines
// and steers the controller into and out of interrupt service at instruction
// boundaries. Optional macro NESTED_NMI_EN lets an NMI preempt a maskable
// handler once, with the preempted vector kept in a shadow register.
module interrupt_arbiter #(
   parameter int N_IRQ = 4,
   parameter int VEC_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             nmi,
   input  logic [N_IRQ-1:0] irq,
   input  logic             int_dis,
   input  logic             instr_boundary,
   input  logic             eret,
   output logic             take_int,
   output logic             int_ack,
   output logic [VEC_W-1:0] int_vec,
   output logic             in_service,
   output logic             nmi_active
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      SERVICE = 2'd2
   } stateT;

   stateT            state;
   stateT            nextState;
   logic             nmiPrev;
   logic             nmiPending;
   logic             nmiEdge;
   logic [VEC_W-1:0] intVecReg;
   logic             nmiActiveReg;
   logic [VEC_W-1:0] winnerVec;
   logic             winnerIsNmi;
   logic             anyIrq;
   logic             anyEligible;
   logic             takeNew;
   logic             nestNmi;
   logic             nestedReg;
`ifdef NESTED_NMI_EN
   logic [VEC_W-1:0] shadowVec;
`endif

   assign nmiEdge = nmi & ~nmiPrev;

   // Priority pick: NMI first, then the lowest-numbered unmasked irq line
   always_comb begin
      winnerVec = '0;
      anyIrq    = 1'b0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (irq[i] && !int_dis) begin
            winnerVec = VEC_W'(i + 1);
            anyIrq    = 1'b1;
         end
      end
      winnerIsNmi = nmiPending;
      if (nmiPending) begin
         winnerVec = '0;
      end
      anyEligible = nmiPending | anyIrq;
   end

   // Decide when a fresh interrupt or a nested NMI is taken this cycle
   always_comb begin
      takeNew = (state == IDLE) && instr_boundary && anyEligible;
`ifdef NESTED_NMI_EN
      nestNmi = (state == SERVICE) && !nmiActiveReg && nmiPending &&
                instr_boundary && !eret;
`else
      nestNmi = 1'b0;
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; eret out of a nested NMI returns to the outer handler
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = takeNew ? ACK : IDLE;
         ACK:     nextState = SERVICE;
         SERVICE: begin
            if (eret) begin
               nextState = nestedReg ? SERVICE : IDLE;
            end else if (nestNmi) begin
               nextState = ACK;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Output decode; a nested acknowledge still counts as handler active
   always_comb begin
      take_int   = (state == ACK);
      int_ack    = (state == ACK);
      in_service = (state == SERVICE) || ((state == ACK) && nestedReg);
      int_vec    = intVecReg;
      nmi_active = nmiActiveReg;
   end

   // NMI edge capture, vector/NMI-flag bookkeeping and the nesting shadow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmiPrev      <= 1'b0;
         nmiPending   <= 1'b0;
         intVecReg    <= '0;
         nmiActiveReg <= 1'b0;
         nestedReg    <= 1'b0;
`ifdef NESTED_NMI_EN
         shadowVec    <= '0;
`endif
      end else begin
         nmiPrev <= nmi;
         if (nmiEdge) begin
            nmiPending <= 1'b1;
         end else if ((state == ACK) && nmiActiveReg) begin
            nmiPending <= 1'b0;
         end
         if (takeNew) begin
            intVecReg    <= winnerVec;
            nmiActiveReg <= winnerIsNmi;
         end else if (nestNmi) begin
`ifdef NESTED_NMI_EN
            shadowVec    <= intVecReg;
`endif
            intVecReg    <= '0;
            nmiActiveReg <= 1'b1;
            nestedReg    <= 1'b1;
         end else if ((state == SERVICE) && eret) begin
            if (nestedReg) begin
`ifdef NESTED_NMI_EN
               intVecReg <= shadowVec;
`endif
               nmiActiveReg <= 1'b0;
               nestedReg    <= 1'b0;
            end else begin
               intVecReg    <= '0;
               nmiActiveReg <= 1'b0;
            end
         end
      end
   end

endmodule
